// File: rtl/pit_count_if.sv
// Control/status bundle between the PIT register block and the pit_count counter stage.
interface pit_count_if #(
    parameter int unsigned COUNT_SIZE = 16
);
    logic [COUNT_SIZE-1:0] mod_value;
    logic [3:0]            pit_pre_scl;
    logic                  pit_slave;
    logic                  pit_cnt_en;
    logic                  pit_flg_clr;
    logic                  ext_sync_i;
    logic                  ext_pre_tick_i;
    logic [COUNT_SIZE-1:0] cnt_n;
    logic                  cnt_flag_o;
    logic                  pit_flag;
    logic                  pre_tick_o;

    modport master (
        output mod_value, pit_pre_scl, pit_slave, pit_cnt_en, pit_flg_clr,
        output ext_sync_i, ext_pre_tick_i,
        input  cnt_n, cnt_flag_o, pit_flag, pre_tick_o
    );

    modport slave (
        input  mod_value, pit_pre_scl, pit_slave, pit_cnt_en, pit_flg_clr,
        input  ext_sync_i, ext_pre_tick_i,
        output cnt_n, cnt_flag_o, pit_flag, pre_tick_o
    );
endinterface

// File: rtl/pit_count.sv
// PIT counter stage: prescaler, modulo counter, rollover pulse and sticky flag.
// Define PIT_PRESCALE_EN to build the 2^pit_pre_scl prescaler; otherwise a master ticks every cycle.
module pit_count #(
    parameter int unsigned COUNT_SIZE = 16
) (
    input logic          bus_clk,
    input logic          sync_reset,
    pit_count_if.slave   bus
);

    logic                  en;
    logic                  tick;
    logic                  rollover;
    logic [COUNT_SIZE-1:0] cnt_q;
    logic                  cnt_flag_q;
    logic                  pit_flag_q;

    assign en = bus.pit_slave ? bus.ext_sync_i : bus.pit_cnt_en;

`ifdef PIT_PRESCALE_EN
    logic [14:0] pre_cnt_q;
    logic [14:0] pre_term;

    assign pre_term = 15'((16'd1 << bus.pit_pre_scl) - 16'd1);
    assign tick     = bus.pit_slave ? (en & bus.ext_pre_tick_i)
                                    : (en & (pre_cnt_q == pre_term));

    // Slave mode parks the local prescaler; a lowered terminal runs on to the 15-bit wrap.
    always_ff @(posedge bus_clk) begin
        if (sync_reset) begin
            pre_cnt_q <= '0;
        end else if (!en || bus.pit_slave || tick) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + 15'd1;
        end
    end
`else
    logic [3:0] unused_pre_scl;

    assign unused_pre_scl = bus.pit_pre_scl;
    assign tick           = bus.pit_slave ? (en & bus.ext_pre_tick_i) : en;
`endif

    // Compare with >= so a lowered modulo rolls over at once instead of wrapping.
    assign rollover = tick & (cnt_q >= bus.mod_value);

    always_ff @(posedge bus_clk) begin
        if (sync_reset) begin
            cnt_q      <= COUNT_SIZE'(1);
            cnt_flag_q <= 1'b0;
            pit_flag_q <= 1'b0;
        end else begin
            if (!en || rollover) begin
                cnt_q <= COUNT_SIZE'(1);
            end else if (tick) begin
                cnt_q <= cnt_q + COUNT_SIZE'(1);
            end
            cnt_flag_q <= rollover;
            if (rollover) begin
                pit_flag_q <= 1'b1;
            end else if (bus.pit_flg_clr) begin
                pit_flag_q <= 1'b0;
            end
        end
    end

    assign bus.cnt_n      = cnt_q;
    assign bus.cnt_flag_o = cnt_flag_q;
    assign bus.pit_flag   = pit_flag_q;
    assign bus.pre_tick_o = tick;

endmodule

// File: tb/tb_pit_count.sv
// Directed bench for pit_count: a master instance plus a slave chained to its tick and enable.
module tb_pit_count;

`ifdef PIT_PRESCALE_EN
    localparam bit PreEn = 1'b1;
`else
    localparam bit PreEn = 1'b0;
`endif

    logic bus_clk;
    logic sync_reset;
    int   n_cmp;
    int   n_err;

    pit_count_if #(.COUNT_SIZE(16)) mif ();
    pit_count_if #(.COUNT_SIZE(16)) sif ();

    pit_count #(.COUNT_SIZE(16)) u_master (
        .bus_clk    (bus_clk),
        .sync_reset (sync_reset),
        .bus        (mif)
    );

    pit_count #(.COUNT_SIZE(16)) u_slave (
        .bus_clk    (bus_clk),
        .sync_reset (sync_reset),
        .bus        (sif)
    );

    assign sif.ext_sync_i     = mif.pit_cnt_en;
    assign sif.ext_pre_tick_i = mif.pre_tick_o;

    initial begin
        bus_clk = 1'b0;
        forever #5 bus_clk = ~bus_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge bus_clk);
    endtask

    initial begin
        int p;
        int t;
        n_cmp = 0;
        n_err = 0;

        sync_reset          = 1'b1;
        mif.mod_value       = 16'd4;
        mif.pit_pre_scl     = 4'd0;
        mif.pit_slave       = 1'b0;
        mif.pit_cnt_en      = 1'b0;
        mif.pit_flg_clr     = 1'b0;
        mif.ext_sync_i      = 1'b0;
        mif.ext_pre_tick_i  = 1'b0;
        sif.mod_value       = 16'd4;
        sif.pit_pre_scl     = 4'd0;
        sif.pit_slave       = 1'b1;
        sif.pit_cnt_en      = 1'b0;
        sif.pit_flg_clr     = 1'b0;
        step();
        step();

        chk("reset cnt_n", 32'(mif.cnt_n), 32'd1);
        chk("reset cnt_flag_o", 32'(mif.cnt_flag_o), 32'd0);
        chk("reset pit_flag", 32'(mif.pit_flag), 32'd0);
        chk("reset pre_tick_o", 32'(mif.pre_tick_o), 32'd0);

        // mod 4, scl 0: 2,3,4,1 repeating
        sync_reset     = 1'b0;
        mif.pit_cnt_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("mod4 cnt_n", 32'(mif.cnt_n), (i % 4 == 3) ? 32'd1 : 32'(i % 4 + 2));
            chk("mod4 cnt_flag_o", 32'(mif.cnt_flag_o), (i % 4 == 3) ? 32'd1 : 32'd0);
            chk("mod4 pit_flag", 32'(mif.pit_flag), (i >= 3) ? 32'd1 : 32'd0);
            chk("mod4 pre_tick_o", 32'(mif.pre_tick_o), 32'd1);
        end

        // Clear alone, then clear coincident with rollover
        mif.pit_flg_clr = 1'b1;
        step();
        chk("clr alone pit_flag", 32'(mif.pit_flag), 32'd0);
        chk("clr alone cnt_n", 32'(mif.cnt_n), 32'd2);
        mif.pit_flg_clr = 1'b0;
        step();
        step();
        chk("pre-roll cnt_n", 32'(mif.cnt_n), 32'd4);
        chk("pre-roll pit_flag", 32'(mif.pit_flag), 32'd0);
        mif.pit_flg_clr = 1'b1;
        step();
        chk("set+clr pit_flag", 32'(mif.pit_flag), 32'd1);
        chk("set+clr cnt_flag_o", 32'(mif.cnt_flag_o), 32'd1);
        chk("set+clr cnt_n", 32'(mif.cnt_n), 32'd1);
        mif.pit_flg_clr = 1'b0;

        // Lower modulo below current count
        mif.mod_value = 16'd100;
        for (int i = 0; i < 49; i++) step();
        chk("mod100 cnt_n", 32'(mif.cnt_n), 32'd50);
        chk("mod100 cnt_flag_o", 32'(mif.cnt_flag_o), 32'd0);
        mif.mod_value = 16'd3;
        step();
        chk("lowered cnt_n", 32'(mif.cnt_n), 32'd1);
        chk("lowered cnt_flag_o", 32'(mif.cnt_flag_o), 32'd1);
        step();
        chk("mod3 cnt_n a", 32'(mif.cnt_n), 32'd2);
        chk("mod3 cnt_flag_o a", 32'(mif.cnt_flag_o), 32'd0);
        step();
        chk("mod3 cnt_n b", 32'(mif.cnt_n), 32'd3);
        step();
        chk("mod3 cnt_n c", 32'(mif.cnt_n), 32'd1);
        chk("mod3 cnt_flag_o c", 32'(mif.cnt_flag_o), 32'd1);

        // Reset mid-count
        mif.mod_value = 16'd100;
        for (int i = 0; i < 6; i++) step();
        chk("midcount cnt_n", 32'(mif.cnt_n), 32'd7);
        chk("midcount pit_flag", 32'(mif.pit_flag), 32'd1);
        sync_reset = 1'b1;
        step();
        chk("midreset cnt_n", 32'(mif.cnt_n), 32'd1);
        chk("midreset pit_flag", 32'(mif.pit_flag), 32'd0);
        chk("midreset cnt_flag_o", 32'(mif.cnt_flag_o), 32'd0);
        sync_reset    = 1'b0;
        mif.mod_value = 16'd3;
        step();
        step();
        chk("pre-disable cnt_n", 32'(mif.cnt_n), 32'd3);
        // Disable on the edge that would have rolled over
        mif.pit_cnt_en = 1'b0;
        step();
        chk("disable cnt_n", 32'(mif.cnt_n), 32'd1);
        chk("disable cnt_flag_o", 32'(mif.cnt_flag_o), 32'd0);
        chk("disable pit_flag", 32'(mif.pit_flag), 32'd0);
        chk("disable pre_tick_o", 32'(mif.pre_tick_o), 32'd0);

        // scl 3, mod 2: tick every 8 cycles, rollover every 16
        p               = PreEn ? 8 : 1;
        mif.pit_pre_scl = 4'd3;
        mif.mod_value   = 16'd2;
        mif.pit_cnt_en  = 1'b1;
        for (int j = 0; j < 40; j++) begin
            #1;
            chk("scl3 pre_tick_o", 32'(mif.pre_tick_o), (j % p == p - 1) ? 32'd1 : 32'd0);
            step();
            t = (j + 1) / p;
            chk("scl3 cnt_n", 32'(mif.cnt_n), (t % 2 == 1) ? 32'd2 : 32'd1);
            chk("scl3 cnt_flag_o", 32'(mif.cnt_flag_o),
                ((j % p == p - 1) && (t % 2 == 0)) ? 32'd1 : 32'd0);
        end

        // Master/slave pair, scl 2, mod 5
        mif.pit_cnt_en = 1'b0;
        step();
        chk("pair idle master", 32'(mif.cnt_n), 32'd1);
        chk("pair idle slave", 32'(sif.cnt_n), 32'd1);
        p               = PreEn ? 4 : 1;
        mif.pit_pre_scl = 4'd2;
        mif.mod_value   = 16'd5;
        sif.mod_value   = 16'd5;
        mif.pit_cnt_en  = 1'b1;
        for (int j = 0; j < 30; j++) begin
            #1;
            chk("slave pre_tick_o", 32'(sif.pre_tick_o), (j % p == p - 1) ? 32'd1 : 32'd0);
            step();
            t = (j + 1) / p;
            chk("pair master cnt_n", 32'(mif.cnt_n), 32'(t % 5 + 1));
            chk("pair slave cnt_n", 32'(sif.cnt_n), 32'(t % 5 + 1));
            chk("pair slave cnt_flag_o", 32'(sif.cnt_flag_o),
                ((j % p == p - 1) && (t % 5 == 0)) ? 32'd1 : 32'd0);
            chk("pair master cnt_flag_o", 32'(mif.cnt_flag_o),
                ((j % p == p - 1) && (t % 5 == 0)) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
